// File: rtl/seven_segments_decoder_if.sv
// Segment-line inputs and decoded score outputs of seven_segments_decoder.
// master drives the segment lines, slave is the decoder.
interface seven_segments_decoder_if;
    logic       i_Segment_A;
    logic       i_Segment_B;
    logic       i_Segment_C;
    logic       i_Segment_D;
    logic       i_Segment_E;
    logic       i_Segment_F;
    logic       i_Segment_G;
    logic [3:0] o_Score;
    logic       o_Valid;
    logic       o_Error;
    logic       o_Busy;
    logic       o_Blank;

    modport master (
        output i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
        output i_Segment_E, i_Segment_F, i_Segment_G,
        input  o_Score, o_Valid, o_Error, o_Busy, o_Blank
    );

    modport slave (
        input  i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
        input  i_Segment_E, i_Segment_F, i_Segment_G,
        output o_Score, o_Valid, o_Error, o_Busy, o_Blank
    );
endinterface

// File: rtl/seven_segments_decoder.sv
// Debounced seven-segment to score decoder for the score display loopback.
// Optional blank detection enabled by SEVEN_SEG_BLANK_DETECT_EN.
module seven_segments_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic                     i_Clk,
    input logic                     i_Reset,
    seven_segments_decoder_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETTLING = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       seg_raw;
    logic [6:0]       sync1_d, sync1_q;
    logic [6:0]       sync2_d, sync2_q;
    logic [6:0]       pattern;
    logic [6:0]       cand_d, cand_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [1:0]       state_d, state_q;
    logic [3:0]       score_d, score_q;
    logic             valid_d, valid_q;
    logic             error_d, error_q;
    logic             busy_d, busy_q;
    logic             blank_d, blank_q;
    logic [3:0]       dec_val;
    logic             dec_ok;
    logic             dec_blank;
    logic             commit;

    assign seg_raw = {bus.i_Segment_A, bus.i_Segment_B, bus.i_Segment_C,
                      bus.i_Segment_D, bus.i_Segment_E, bus.i_Segment_F,
                      bus.i_Segment_G};

    // Lines are active-low; the pattern is active-high with A at bit 6.
    assign sync1_d = seg_raw;
    assign sync2_d = sync1_q;
    assign pattern = ~sync2_q;

    always_comb begin
        dec_val = 4'h0;
        dec_ok  = 1'b1;
        case (pattern)
            7'h7E:   dec_val = 4'h0;
            7'h30:   dec_val = 4'h1;
            7'h6D:   dec_val = 4'h2;
            7'h79:   dec_val = 4'h3;
            7'h33:   dec_val = 4'h4;
            7'h5B:   dec_val = 4'h5;
            7'h5F:   dec_val = 4'h6;
            7'h70:   dec_val = 4'h7;
            7'h7F:   dec_val = 4'h8;
            7'h7B:   dec_val = 4'h9;
            7'h47:   dec_val = 4'hF;
            default: dec_ok  = 1'b0;
        endcase
`ifdef SEVEN_SEG_BLANK_DETECT_EN
        dec_blank = (pattern == 7'h00);
`else
        dec_blank = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        count_d = count_q;
        commit  = 1'b0;
        case (state_q)
            SETTLING: begin
                if (pattern != cand_q) begin
                    cand_d  = pattern;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    commit  = 1'b1;
                    state_d = LOCKED;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                if (pattern != cand_q) begin
                    cand_d  = pattern;
                    count_d = '0;
                    state_d = SETTLING;
                end
            end
        endcase
    end

    always_comb begin
        score_d = score_q;
        valid_d = 1'b0;
        error_d = error_q;
        blank_d = blank_q;
        if (commit) begin
            if (dec_blank) begin
                blank_d = 1'b1;
                error_d = 1'b0;
            end else if (dec_ok) begin
                score_d = dec_val;
                valid_d = 1'b1;
                error_d = 1'b0;
                blank_d = 1'b0;
            end else begin
                error_d = 1'b1;
                blank_d = 1'b0;
            end
        end
        busy_d = (state_d == SETTLING);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= 7'h7F;
            sync2_q <= 7'h7F;
            cand_q  <= 7'h00;
            count_q <= '0;
            state_q <= IDLE;
            score_q <= 4'h0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            state_q <= state_d;
            score_q <= score_d;
            valid_q <= valid_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            blank_q <= blank_d;
        end
    end

    assign bus.o_Score = score_q;
    assign bus.o_Valid = valid_q;
    assign bus.o_Error = error_q;
    assign bus.o_Busy  = busy_q;
    assign bus.o_Blank = blank_q;
endmodule

// File: tb/tb_seven_segments_decoder.sv
// Directed bench for seven_segments_decoder: STABLE_CYCLES=4 and =1 instances.
// Expected blank/error on an all-off pattern follows SEVEN_SEG_BLANK_DETECT_EN.
module tb_seven_segments_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seven_segments_decoder_if bus_a ();
    seven_segments_decoder_if bus_b ();

    seven_segments_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus_a)
    );

    seven_segments_decoder #(.STABLE_CYCLES(1), .CNT_W(8)) dut_b (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus_b)
    );

`ifdef SEVEN_SEG_BLANK_DETECT_EN
    localparam logic BL = 1'b1;
`else
    localparam logic BL = 1'b0;
`endif

    typedef struct {
        logic [6:0] pat;
        int         cyc;
        int         pulses;
        logic [3:0] score;
        logic       err;
        logic       blank;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [6:0] pat);
        {bus_a.i_Segment_A, bus_a.i_Segment_B, bus_a.i_Segment_C,
         bus_a.i_Segment_D, bus_a.i_Segment_E, bus_a.i_Segment_F,
         bus_a.i_Segment_G} = ~pat;
    endtask

    task automatic drive_b(input logic [6:0] pat);
        {bus_b.i_Segment_A, bus_b.i_Segment_B, bus_b.i_Segment_C,
         bus_b.i_Segment_D, bus_b.i_Segment_E, bus_b.i_Segment_F,
         bus_b.i_Segment_G} = ~pat;
    endtask

    task automatic run_a(input int n, output int pulses, output int at,
                         output logic [3:0] psc);
        pulses = 0;
        at     = 0;
        psc    = 4'h0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_a.o_Valid === 1'b1) begin
                pulses++;
                at  = i;
                psc = bus_a.o_Score;
            end
        end
    endtask

    task automatic run_b(input int n, output int pulses, output int at,
                         output logic [3:0] psc);
        pulses = 0;
        at     = 0;
        psc    = 4'h0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_b.o_Valid === 1'b1) begin
                pulses++;
                at  = i;
                psc = bus_b.o_Score;
            end
        end
    endtask

    function automatic vec_t mk(input logic [6:0] pat, input int cyc,
                                input int pulses, input logic [3:0] score,
                                input logic err, input logic blank,
                                input logic busy);
        vec_t v;
        v.pat    = pat;
        v.cyc    = cyc;
        v.pulses = pulses;
        v.score  = score;
        v.err    = err;
        v.blank  = blank;
        v.busy   = busy;
        return v;
    endfunction

    initial begin
        int         p;
        int         at;
        logic [3:0] ps;
        logic [6:0] pb;

        tbl.push_back(mk(7'h5B, 10, 1, 4'h5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h7F,  2, 0, 4'h5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h5B, 12, 1, 4'h5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h47, 10, 1, 4'hF, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h01, 10, 0, 4'hF, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(7'h30, 10, 1, 4'h1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h00, 10, 0, 4'h1, ~BL,  BL,   1'b0));
        tbl.push_back(mk(7'h70, 10, 1, 4'h7, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h00, 10, 0, 4'h7, ~BL,  BL,   1'b0));
        tbl.push_back(mk(7'h7E, 10, 1, 4'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h6D,  3, 0, 4'h0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(7'h6D, 10, 1, 4'h2, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h12, 10, 0, 4'h2, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(7'h5F, 10, 1, 4'h6, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h7B, 10, 1, 4'h9, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(7'h33, 10, 1, 4'h4, 1'b0, 1'b0, 1'b0));

        drive_a(7'h00);
        drive_b(7'h00);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_score", bus_a.o_Score, 4'h0);
        check("rst_valid", bus_a.o_Valid, 1'b0);
        check("rst_error", bus_a.o_Error, 1'b0);
        check("rst_busy",  bus_a.o_Busy,  1'b0);
        check("rst_blank", bus_a.o_Blank, 1'b0);
        rst = 1'b0;
        run_a(3, p, at, ps);
        check("idle_pulses", p, 0);

        // Latency: change before e0, pulse visible after the 7th edge.
        drive_a(7'h79);
        run_a(10, p, at, ps);
        check("lat_pulses", p, 1);
        check("lat_edge",   at, 7);
        check("lat_score",  ps, 4'h3);
        check("lat_error",  bus_a.o_Error, 1'b0);

        foreach (tbl[i]) begin
            drive_a(tbl[i].pat);
            run_a(tbl[i].cyc, p, at, ps);
            check($sformatf("v%0d_pulses", i), p, tbl[i].pulses);
            if (p > 0)
                check($sformatf("v%0d_pscore", i), ps, tbl[i].score);
            check($sformatf("v%0d_score", i), bus_a.o_Score, tbl[i].score);
            check($sformatf("v%0d_error", i), bus_a.o_Error, tbl[i].err);
            check($sformatf("v%0d_blank", i), bus_a.o_Blank, tbl[i].blank);
            check($sformatf("v%0d_busy",  i), bus_a.o_Busy,  tbl[i].busy);
        end

        // Reset lands on the edge that would commit 9.
        drive_a(7'h7B);
        run_a(6, p, at, ps);
        check("pre_rst_pulses", p, 0);
        check("pre_rst_busy", bus_a.o_Busy, 1'b1);
        rst = 1'b1;
        run_a(1, p, at, ps);
        check("rst9_pulses", p, 0);
        check("rst9_score", bus_a.o_Score, 4'h0);
        check("rst9_busy",  bus_a.o_Busy,  1'b0);
        check("rst9_error", bus_a.o_Error, 1'b0);
        rst = 1'b0;
        run_a(10, p, at, ps);
        check("post_rst_pulses", p, 1);
        check("post_rst_edge", at, 7);
        check("post_rst_score", bus_a.o_Score, 4'h9);

        // STABLE_CYCLES=1: toggle 1/2 every 4 cycles.
        for (int w = 0; w < 6; w++) begin
            pb = (w % 2 == 0) ? 7'h30 : 7'h6D;
            drive_b(pb);
            run_b(4, p, at, ps);
            check($sformatf("b%0d_pulses", w), p, 1);
            check($sformatf("b%0d_edge", w), at, 4);
            check($sformatf("b%0d_score", w), ps,
                  (w % 2 == 0) ? 4'h1 : 4'h2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
